gfx_stream_arb: RTL

Round-robin arbiter that shares one graphics pixel stream (valid/x/y/pixel/ready) between NUM_SRC drawing engines such as rect fill, line and clear. It sits between the drawing primitives and the framebuffer writer. It replaces ad-hoc state-based muxing with a fair, back-pressure-correct registered output stage. A per-source lock keeps a primitive's beats contiguous when a requester needs atomic access.

---
 rtl/gfx_stream_arb_if.sv | 33 +++
 rtl/gfx_stream_arb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/gfx_stream_arb_if.sv
// Pixel-stream bundle between the drawing engines, the round-robin arbiter and the framebuffer writer.
// The slave view belongs to the arbiter; the master view belongs to the engines and writer around it.
interface gfx_stream_arb_if #(
  parameter int NUM_SRC     = 2,
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12,
  parameter int PIXEL_WIDTH = 12,
  parameter int SRC_WIDTH   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic [NUM_SRC-1:0]             s_gfx_valid;
  logic [NUM_SRC-1:0]             s_gfx_lock;
  logic [NUM_SRC*H_WIDTH-1:0]     s_gfx_x;
  logic [NUM_SRC*V_WIDTH-1:0]     s_gfx_y;
  logic [NUM_SRC*PIXEL_WIDTH-1:0] s_gfx_pixel;
  logic [NUM_SRC-1:0]             s_gfx_ready;
  logic                           m_gfx_valid;
  logic [H_WIDTH-1:0]             m_gfx_x;
  logic [V_WIDTH-1:0]             m_gfx_y;
  logic [PIXEL_WIDTH-1:0]         m_gfx_pixel;
  logic [SRC_WIDTH-1:0]           m_gfx_src;
  logic                           m_gfx_ready;
  logic                           locked;

  modport slave (
    input  s_gfx_valid, s_gfx_lock, s_gfx_x, s_gfx_y, s_gfx_pixel, m_gfx_ready,
    output s_gfx_ready, m_gfx_valid, m_gfx_x, m_gfx_y, m_gfx_pixel, m_gfx_src, locked
  );

  modport master (
    output s_gfx_valid, s_gfx_lock, s_gfx_x, s_gfx_y, s_gfx_pixel, m_gfx_ready,
    input  s_gfx_ready, m_gfx_valid, m_gfx_x, m_gfx_y, m_gfx_pixel, m_gfx_src, locked
  );
endinterface

// File: rtl/gfx_stream_arb.sv
// Round-robin arbiter sharing one registered pixel stream between NUM_SRC drawing engines,
// with a per-source lock that keeps a primitive's beats contiguous.
module gfx_stream_arb #(
  parameter int NUM_SRC     = 2,
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12,
  parameter int PIXEL_WIDTH = 12,
  parameter int SRC_WIDTH   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  gfx_stream_arb_if.slave  gfx
);

  localparam logic [SRC_WIDTH:0]   NUM_SRC_W = (SRC_WIDTH+1)'(NUM_SRC);
  localparam logic [SRC_WIDTH-1:0] LAST_SRC  = SRC_WIDTH'(NUM_SRC - 1);

  typedef enum logic [0:0] {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  lock_state_t            lock_state_r;
  lock_state_t            lock_state_nxt_s;
  logic [SRC_WIDTH-1:0]   lock_src_r;
  logic [SRC_WIDTH-1:0]   rr_ptr_r;
  logic [SRC_WIDTH-1:0]   sel_s;
  logic                   has_sel_s;
  logic                   slot_free_s;
  logic                   accept_s;
  logic                   sel_lock_s;
  logic [NUM_SRC-1:0]     ready_s;
  logic [H_WIDTH-1:0]     sel_x_s;
  logic [V_WIDTH-1:0]     sel_y_s;
  logic [PIXEL_WIDTH-1:0] sel_pixel_s;
  logic                   m_valid_r;
  logic [H_WIDTH-1:0]     m_x_r;
  logic [V_WIDTH-1:0]     m_y_r;
  logic [PIXEL_WIDTH-1:0] m_pixel_r;
  logic [SRC_WIDTH-1:0]   m_src_r;

  // Lock holder overrides arbitration; otherwise the scan runs downward so the
  // source closest to rr_ptr in rotating order is the last one written and wins.
  always_comb begin
    logic [SRC_WIDTH:0]   scan_v;
    logic [SRC_WIDTH-1:0] idx_v;
    scan_v    = '0;
    idx_v     = '0;
    sel_s     = '0;
    has_sel_s = 1'b0;
    if (lock_state_r == LOCK_HELD) begin
      sel_s     = lock_src_r;
      has_sel_s = gfx.s_gfx_valid[lock_src_r];
    end else begin
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        scan_v    = {1'b0, rr_ptr_r} + (SRC_WIDTH+1)'(k);
        scan_v    = (scan_v >= NUM_SRC_W) ? (scan_v - NUM_SRC_W) : scan_v;
        idx_v     = scan_v[SRC_WIDTH-1:0];
        sel_s     = gfx.s_gfx_valid[idx_v] ? idx_v : sel_s;
        has_sel_s = has_sel_s | gfx.s_gfx_valid[idx_v];
      end
    end
  end

  // has_sel_s already implies the selected source is valid, so ready doubles as accept.
  always_comb begin
    slot_free_s = !m_valid_r || gfx.m_gfx_ready;
    accept_s    = rst_n && slot_free_s && has_sel_s;
    sel_lock_s  = gfx.s_gfx_lock[sel_s];
    sel_x_s     = gfx.s_gfx_x[int'(sel_s)*H_WIDTH +: H_WIDTH];
    sel_y_s     = gfx.s_gfx_y[int'(sel_s)*V_WIDTH +: V_WIDTH];
    sel_pixel_s = gfx.s_gfx_pixel[int'(sel_s)*PIXEL_WIDTH +: PIXEL_WIDTH];
    ready_s     = '0;
    if (accept_s) begin
      ready_s[sel_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state_r <= LOCK_IDLE;
    end else begin
      lock_state_r <= lock_state_nxt_s;
    end
  end

  // Lock next-state: any accepted beat's lock bit decides whether the grant is held.
  always_comb begin
    lock_state_nxt_s = lock_state_r;
    case (lock_state_r)
      LOCK_IDLE: begin
        if (accept_s && sel_lock_s) begin
          lock_state_nxt_s = LOCK_HELD;
        end else begin
          lock_state_nxt_s = LOCK_IDLE;
        end
      end
      LOCK_HELD: begin
        if (accept_s && !sel_lock_s) begin
          lock_state_nxt_s = LOCK_IDLE;
        end else begin
          lock_state_nxt_s = LOCK_HELD;
        end
      end
      default: lock_state_nxt_s = LOCK_IDLE;
    endcase
  end

  // rr_ptr moves past every granted source, lock holder included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r   <= '0;
      lock_src_r <= '0;
    end else if (accept_s) begin
      rr_ptr_r   <= (sel_s == LAST_SRC) ? '0 : sel_s + SRC_WIDTH'(1);
      lock_src_r <= sel_lock_s ? sel_s : lock_src_r;
    end else begin
      rr_ptr_r   <= rr_ptr_r;
      lock_src_r <= lock_src_r;
    end
  end

  // Output slot: load on accept, retire on downstream ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_x_r     <= '0;
      m_y_r     <= '0;
      m_pixel_r <= '0;
      m_src_r   <= '0;
    end else if (accept_s) begin
      m_valid_r <= 1'b1;
      m_x_r     <= sel_x_s;
      m_y_r     <= sel_y_s;
      m_pixel_r <= sel_pixel_s;
      m_src_r   <= sel_s;
    end else if (gfx.m_gfx_ready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  assign gfx.s_gfx_ready = ready_s;
  assign gfx.m_gfx_valid = m_valid_r;
  assign gfx.m_gfx_x     = m_x_r;
  assign gfx.m_gfx_y     = m_y_r;
  assign gfx.m_gfx_pixel = m_pixel_r;
  assign gfx.m_gfx_src   = m_src_r;
  assign gfx.locked      = (lock_state_r == LOCK_HELD);

endmodule
